char_buffer_writer: RTL and testbench
=====================================

# char_buffer_writer

Character buffer and number writer that serves the font-rendering stage. It holds a 256-entry character-code RAM and answers the renderer's per-cell read address with a registered character code. On the write side, game logic either pokes single characters or requests that a 16-bit value (score, length) be written as decimal ASCII digits into a fixed field. The block sits between the game-state logic and the on-screen text overlay.

## Interface
Parameters:
- `FIELD_ADDR`, 0: buffer address of the most significant digit of the number field.
- `NUM_DIGITS`, 5: digits written, legal range 1..5.
- `LEADING_BLANK`, 1: 1 replaces leading zeros with `BLANK_CODE`; 0 writes them as `'0'`.
- `BLANK_CODE`, 8'h20: code for blank cells.

Ports:
- `clk`, input, 1: pixel clock. Single clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `char_xy`, input, 8: read address (cell index) from the renderer.
- `char_code`, output, 8: code stored at `char_xy`. Registered.
- `wr_en`, input, 1: direct single-character write strobe.
- `wr_addr`, input, 8: address for the direct write.
- `wr_data`, input, 8: character code for the direct write.
- `value_in`, input, 16: unsigned value to be written as decimal.
- `value_valid`, input, 1: one-cycle request to write `value_in`.
- `busy`, output, 1: number write in progress. New requests are ignored while it is high.
- `done`, output, 1: one-cycle pulse when a number write completes.

## Operation
- **RAM:** 256 x 8.
  - Power-up content is `BLANK_CODE` in every cell (FPGA initial value). Reset does not clear the RAM.
  - One write port, one read port.
  - Read is read-first: a read and write to the same address in the same cycle returns the old data.
- **FSM states:** IDLE, CONVERT, WRITE, DONE.
  - **IDLE:**
    - `wr_en=1` writes `wr_data` to `wr_addr` in that cycle.
    - `value_valid=1` latches `value_in`, clears the BCD register and the iteration counter, and goes to CONVERT.
    - Both asserted in the same cycle: the direct write is performed and the conversion also starts.
  - **CONVERT:** 16 double-dabble iterations, one per cycle.
    - Each iteration: add 3 to every BCD nibble ≥ 5, then shift the 20-bit BCD and 16-bit binary registers left by one as a combined register.
    - After the 16th iteration, go to WRITE.
  - **WRITE:** one digit per cycle, most significant first, digit index i = 0..NUM_DIGITS-1.
    - Address is `FIELD_ADDR + i`, modulo 256 (wraps).
    - Code is `8'h30 + nibble`.
    - Leading blanking (`LEADING_BLANK=1`): a digit is `BLANK_CODE` while all higher digits are zero. The last digit is never blanked.
    - Saturation: if `value_in` > 10^NUM_DIGITS − 1, all NUM_DIGITS cells are written `'9'`.
    - After the last digit, go to DONE.
  - **DONE:** `done=1` for one cycle, then go to IDLE.
- **Outputs:**
  - `busy` = 1 in CONVERT, WRITE and DONE.
  - `wr_en` is ignored outside IDLE. The direct write is dropped, not queued.
  - `value_valid` is ignored outside IDLE.
- **Reset:**
  - State goes to IDLE, with `busy=0`, `done=0`, `char_code=BLANK_CODE`.
  - A reset mid-operation aborts the write. Cells already written keep their new values.

## Timing
- Read latency is 1 cycle: `char_code` at cycle n+1 reflects `char_xy` at cycle n. The renderer's address pipeline accounts for this cycle.
- Number write, with the request accepted at cycle 0:
  - `busy` is high from cycle 1.
  - CONVERT occupies cycles 1..16.
  - Digit i is written at cycle 17+i.
  - `done` is high at cycle 17+NUM_DIGITS.
  - `busy` is low and a new request is accepted from cycle 18+NUM_DIGITS.
  - Total occupancy is 17+NUM_DIGITS cycles (22 at the default).
- A digit written at cycle k is readable via `char_code` at cycle k+2 at the earliest: read issued at k+1, registered at k+2.

## Structure
- Shared package `text_pkg` holds:
  - `ASCII_ZERO` = 8'h30.
  - Default `BLANK_CODE`.
  - Buffer depth and address width (256 / 8), shared with the font renderer.
  - The FSM state type: 2-bit encoding IDLE=0, CONVERT=1, WRITE=2, DONE=3.
- Sub-module `bcd_converter` contains the iterative 16-bit to 5-digit double-dabble datapath:
  - Signals: start, 16 cycles of shifting, then a 20-bit BCD output and a valid flag.
  - The top level keeps the RAM, the arbitration between direct and number writes, and the WRITE/DONE sequencing.

## Test plan
- **Read after reset:** reset, then read addresses 0, 17, 255 → `char_code`=8'h20 one cycle after each address.
- **Direct write:** `wr_en` with addr 8'h05 and data 8'h41 in IDLE → read 5 returns 8'h41. A same-cycle read of 5 returns 8'h20 (read-first).
- **Number write with blanking:** `value_in`=1234, `value_valid` at cycle 0 with defaults.
  - Cells 0..4 = 20,31,32,33,34 (hex).
  - `done` pulses at cycle 22; `busy` is low at cycle 23.
- **Zero and maximum values:**
  - `value_in`=0 → cells 20,20,20,20,30.
  - `value_in`=65535 → 36,35,35,33,35.
  - `LEADING_BLANK=0` with 7 → 30,30,30,30,37.
- **Saturation and wrap:**
  - `NUM_DIGITS=3`, `value_in`=1500 → three cells of 8'h39.
  - `FIELD_ADDR=254`, `NUM_DIGITS=3` → writes land at 254, 255, 0.
- **Collisions and reset:**
  - `value_valid` and `wr_en` asserted during CONVERT → both ignored and buffer unchanged.
  - `rst` at cycle 18 of a write → `busy`=0 and `done`=0 next cycle. Only cell `FIELD_ADDR` was updated; a fresh request then completes normally.

Source files
------------

// File: rtl/text_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared text-overlay constants, buffer geometry and the number
//               writer state type.
// Revision    : 1.0
// ============================================================================
package text_pkg;

  localparam logic [7:0] ASCII_ZERO         = 8'h30;
  localparam logic [7:0] DEFAULT_BLANK_CODE = 8'h20;
  localparam int         BUF_DEPTH          = 256;
  localparam int         BUF_AW             = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [16:0] max_decimal(input int unsigned digits);
    logic [16:0] r;
    r = 17'd1;
    for (int unsigned i = 0; i < digits; i++) r = r * 17'd10;
    return r - 17'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_converter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_converter
// Description : Iterative 16-bit binary to 5-digit BCD (double dabble), one
//               iteration per clock, 16 clocks after start.
// Revision    : 1.0
// ============================================================================
module bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic [19:0] bcd,
  output logic        last,
  output logic        valid
);

  logic [15:0] r_bin;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_active;
  logic        r_valid;
  logic [19:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < 5; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_valid  <= 1'b0;
    end else if (start) begin
      r_bin    <= bin_in;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_valid  <= 1'b0;
    end else if (r_active) begin
      {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) begin
        r_active <= 1'b0;
        r_valid  <= 1'b1;
      end
    end
  end

  // Asserted during the final iteration so the caller can advance in step.
  assign last  = r_active && (r_cnt == 4'd15);
  assign bcd   = r_bcd;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/char_buffer_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : char_buffer_writer
// Description : 256x8 character buffer with registered read port, direct
//               character writes and decimal number field writes.
// Revision    : 1.0
// ============================================================================
module char_buffer_writer
  import text_pkg::*;
#(
  parameter int unsigned FIELD_ADDR    = 0,
  parameter int unsigned NUM_DIGITS    = 5,
  parameter bit          LEADING_BLANK = 1'b1,
  parameter logic [7:0]  BLANK_CODE    = DEFAULT_BLANK_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_xy,
  output logic [7:0]  char_code,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [BUF_AW-1:0] c_field_base = BUF_AW'(FIELD_ADDR % BUF_DEPTH);
  localparam logic [2:0]        c_last_idx   = 3'(NUM_DIGITS - 1);
  localparam logic [16:0]       c_max_value  = max_decimal(NUM_DIGITS);

  wr_state_t   r_state;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_idx;
  logic        r_sat;
  logic        r_nonzero;
  logic [7:0]  r_char_code;
  logic [7:0]  r_mem [BUF_DEPTH] = '{default: BLANK_CODE};

  logic        w_start;
  logic [19:0] w_bcd;
  logic        w_bcd_last;
  logic        w_bcd_valid;
  logic [2:0]  w_rev;
  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [7:0]  w_digit_code;
  logic        w_we;
  logic [7:0]  w_waddr;
  logic [7:0]  w_wdata;

  assign w_start = (r_state == ST_IDLE) && value_valid;

  bcd_converter u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .bin_in (value_in),
    .bcd    (w_bcd),
    .last   (w_bcd_last),
    .valid  (w_bcd_valid)
  );

  // Digit r_idx counts from the most significant end of the field.
  always_comb begin
    w_rev    = c_last_idx - r_idx;
    w_nibble = 4'd0;
    for (int d = 0; d < 5; d++) begin
      if (3'(d) == w_rev) w_nibble = w_bcd[4*d +: 4];
    end
    w_blank = LEADING_BLANK && !r_nonzero && (w_nibble == 4'd0) && (r_idx != c_last_idx);
    if (r_sat)        w_digit_code = ASCII_ZERO + 8'd9;
    else if (w_blank) w_digit_code = BLANK_CODE;
    else              w_digit_code = ASCII_ZERO + {4'd0, w_nibble};
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    if (!rst) begin
      if (r_state == ST_WRITE && w_bcd_valid) begin
        w_we    = 1'b1;
        w_waddr = c_field_base + {5'd0, r_idx};
        w_wdata = w_digit_code;
      end else if (r_state == ST_IDLE && wr_en) begin
        w_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_char_code <= BLANK_CODE;
    else     r_char_code <= r_mem[char_xy];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= 3'd0;
      r_sat     <= 1'b0;
      r_nonzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (value_valid) begin
            r_state   <= ST_CONVERT;
            r_busy    <= 1'b1;
            r_idx     <= 3'd0;
            r_nonzero <= 1'b0;
            r_sat     <= ({1'b0, value_in} > c_max_value);
          end
        end
        ST_CONVERT: begin
          if (w_bcd_last) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_nonzero <= r_nonzero || (w_nibble != 4'd0);
          if (r_idx == c_last_idx) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign char_code = r_char_code;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_char_buffer_writer
// Description : Self-checking bench for two configurations of the character
//               buffer writer (defaults, and wrapped 3-digit unblanked field).
// Revision    : 1.0
// ============================================================================
module tb_char_buffer_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_xy = 8'd0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [15:0] value_in = 16'd0;
  logic        value_valid = 1'b0;
  logic [7:0]  code0, code1;
  logic        busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  char_buffer_writer u0 (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(code0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .value_in(value_in), .value_valid(value_valid), .busy(busy0), .done(done0)
  );

  char_buffer_writer #(.FIELD_ADDR(254), .NUM_DIGITS(3), .LEADING_BLANK(1'b0)) u1 (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(code1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .value_in(value_in), .value_valid(value_valid), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, a cell array plus a cycle index t counting
  // from the accepted request (t = -1 when idle).
  int         nd [2] = '{5, 3};
  int         fa [2] = '{0, 254};
  bit         lb [2] = '{1'b1, 1'b0};
  logic [7:0] mmem [2][256];
  int         t [2] = '{-1, -1};
  int         val [2] = '{0, 0};
  logic [7:0] exp_code [2] = '{8'h20, 8'h20};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] digit_code(input int v, input int n, input bit blank_lead, input int i);
    int p;
    p = pow10(n - 1 - i);
    if (v > pow10(n) - 1) return 8'h39;
    if (blank_lead && i < n - 1 && v < p) return 8'h20;
    return 8'(8'h30 + (v / p) % 10);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mmem[k][a] = 8'h20;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_code[k] = rst ? 8'h20 : mmem[k][char_xy];
      if (rst) begin
        t[k] = -1;
      end else if (t[k] < 0) begin
        if (wr_en) mmem[k][wr_addr] = wr_data;
        if (value_valid) begin
          val[k] = int'(value_in);
          t[k]   = 1;
        end
      end else begin
        if (t[k] >= 17 && t[k] < 17 + nd[k])
          mmem[k][8'(fa[k] + t[k] - 17)] = digit_code(val[k], nd[k], lb[k], t[k] - 17);
        t[k] = (t[k] == 17 + nd[k]) ? -1 : t[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("code0", {24'd0, code0}, {24'd0, exp_code[0]});
      chk("code1", {24'd0, code1}, {24'd0, exp_code[1]});
      chk("busy0", {31'd0, busy0}, {31'd0, (t[0] > 0)});
      chk("busy1", {31'd0, busy1}, {31'd0, (t[1] > 0)});
      chk("done0", {31'd0, done0}, {31'd0, (t[0] == 17 + nd[0])});
      chk("done1", {31'd0, done1}, {31'd0, (t[1] == 17 + nd[1])});
    end
  end

  task automatic read_lit(input int which, input logic [7:0] a, input logic [7:0] lit, input string name);
    char_xy = a;
    @(negedge clk);
    chk(name, {24'd0, (which == 0) ? code0 : code1}, {24'd0, lit});
  endtask

  // Returns at the negedge of cycle 1 relative to the accepted request.
  task automatic request(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic run_num(input logic [15:0] v);
    request(v);
    repeat (22) @(negedge clk);
  endtask

  logic [7:0] e5 [5];
  logic [7:0] e3 [3];
  logic [7:0] a3 [3] = '{8'd254, 8'd255, 8'd0};

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    read_lit(0, 8'd0,   8'h20, "rst_rd0");
    read_lit(0, 8'd17,  8'h20, "rst_rd17");
    read_lit(0, 8'd255, 8'h20, "rst_rd255");

    char_xy = 8'd5; wr_addr = 8'd5; wr_data = 8'h41; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("read_first", {24'd0, code0}, 32'h20);
    @(negedge clk);
    chk("direct_wr", {24'd0, code0}, 32'h41);

    request(16'd1234);
    repeat (21) @(negedge clk);
    chk("done_at_22", {31'd0, done0}, 32'd1);
    @(negedge clk);
    chk("idle_at_23", {31'd0, busy0}, 32'd0);
    e5 = '{8'h20, 8'h31, 8'h32, 8'h33, 8'h34};
    for (int i = 0; i < 5; i++) read_lit(0, 8'(i), e5[i], "n1234");

    run_num(16'd0);
    e5 = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
    for (int i = 0; i < 5; i++) read_lit(0, 8'(i), e5[i], "n0");

    run_num(16'd65535);
    e5 = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35};
    for (int i = 0; i < 5; i++) read_lit(0, 8'(i), e5[i], "n65535");

    run_num(16'd7);
    e3 = '{8'h30, 8'h30, 8'h37};
    for (int i = 0; i < 3; i++) read_lit(1, a3[i], e3[i], "noblank7_wrap");
    read_lit(0, 8'd4, 8'h37, "n7_last");

    run_num(16'd1500);
    for (int i = 0; i < 3; i++) read_lit(1, a3[i], 8'h39, "sat1500");
    read_lit(0, 8'd1, 8'h31, "n1500_d1");

    request(16'd100);
    repeat (3) @(negedge clk);
    value_in = 16'd9; value_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'h55;
    @(negedge clk);
    value_valid = 1'b0; wr_en = 1'b0;
    repeat (17) @(negedge clk);
    chk("collide_done22", {31'd0, done0}, 32'd1);
    @(negedge clk);
    read_lit(0, 8'd5, 8'h41, "collide_keep5");
    read_lit(0, 8'd2, 8'h31, "n100_d2");

    request(16'd40000);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    read_lit(0, 8'd0, 8'h34, "abort_cell0");
    read_lit(0, 8'd1, 8'h20, "abort_cell1");

    request(16'd321);
    repeat (21) @(negedge clk);
    chk("fresh_done22", {31'd0, done0}, 32'd1);
    @(negedge clk);
    e3 = '{8'h33, 8'h32, 8'h31};
    for (int i = 0; i < 3; i++) read_lit(0, 8'(i + 2), e3[i], "n321");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
